// File: rtl/fifo_access_ctrl_if.sv
// rtl/fifo_access_ctrl_if.sv - producer, consumer and FIFO-side signals of the FIFO access controller
interface fifo_access_ctrl_if;
  logic       wr0_req;
  logic [7:0] wr0_data;
  logic       wr0_ack;
  logic       wr1_req;
  logic [7:0] wr1_data;
  logic       wr1_ack;
  logic       rd_req;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [2:0] fifo_left;
  logic       fifo_wr_req;
  logic [7:0] fifo_wr_data;
  logic       fifo_rd_req;
  logic [7:0] fifo_rd_data;
  logic       full;
  logic       empty;

  modport slave (
    input  wr0_req, wr0_data, wr1_req, wr1_data, rd_req, fifo_left, fifo_rd_data,
    output wr0_ack, wr1_ack, rd_valid, rd_data, fifo_wr_req, fifo_wr_data, fifo_rd_req,
           full, empty
  );

  modport master (
    output wr0_req, wr0_data, wr1_req, wr1_data, rd_req, fifo_left, fifo_rd_data,
    input  wr0_ack, wr1_ack, rd_valid, rd_data, fifo_wr_req, fifo_wr_data, fifo_rd_req,
           full, empty
  );
endinterface

// File: rtl/fifo_access_ctrl.sv
// rtl/fifo_access_ctrl.sv - round-robin burst write arbiter and read sequencer for a small sync FIFO
module fifo_access_ctrl #(
  parameter logic [2:0] DEEP  = 3'd4,
  parameter logic [2:0] BURST = 3'd2
) (
  input  logic            clk,
  input  logic            rst,
  fifo_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       prio, prio_nxt;
  logic [2:0] beat_cnt, beat_nxt;
  logic       ack0, ack1;
  logic [7:0] wr_data;
  logic       has_room, has_data, last_beat;
  logic       rd_issue;
  logic       rd_pend;
  logic       rd_valid_q;
  logic [7:0] rd_data_q;

  assign has_room  = (bus.fifo_left != 3'd0);
  assign has_data  = (bus.fifo_left != DEEP);
  assign last_beat = (beat_cnt == (BURST - 3'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      beat_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // A grant ends on its last beat or when the producer drops req; the other
  // channel is granted directly if it is waiting, so hand-over costs no cycle.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    beat_nxt  = beat_cnt;
    ack0      = 1'b0;
    ack1      = 1'b0;
    wr_data   = 8'h00;
    case (state)
      IDLE: begin
        if (bus.wr0_req && bus.wr1_req) begin
          state_nxt = prio ? GNT1 : GNT0;
        end else if (bus.wr0_req) begin
          state_nxt = GNT0;
        end else if (bus.wr1_req) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        wr_data = bus.wr0_data;
        ack0    = bus.wr0_req & has_room & ~rst;
        if (!bus.wr0_req || (ack0 && last_beat)) begin
          prio_nxt  = 1'b1;
          beat_nxt  = 3'd0;
          state_nxt = bus.wr1_req ? GNT1 : IDLE;
        end else if (ack0) begin
          beat_nxt = beat_cnt + 3'd1;
        end
      end
      GNT1: begin
        wr_data = bus.wr1_data;
        ack1    = bus.wr1_req & has_room & ~rst;
        if (!bus.wr1_req || (ack1 && last_beat)) begin
          prio_nxt  = 1'b0;
          beat_nxt  = 3'd0;
          state_nxt = bus.wr0_req ? GNT0 : IDLE;
        end else if (ack1) begin
          beat_nxt = beat_cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FIFO read data arrives one cycle after the request; capture it then.
  assign rd_issue = bus.rd_req & has_data & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      rd_pend    <= rd_issue;
      rd_valid_q <= rd_pend;
      if (rd_pend) begin
        rd_data_q <= bus.fifo_rd_data;
      end
    end
  end

  assign bus.wr0_ack      = ack0;
  assign bus.wr1_ack      = ack1;
  assign bus.fifo_wr_req  = ack0 | ack1;
  assign bus.fifo_wr_data = wr_data;
  assign bus.fifo_rd_req  = rd_issue;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.full         = ~has_room;
  assign bus.empty        = ~has_data;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// tb/tb_fifo_access_ctrl.sv - self-checking bench for fifo_access_ctrl with a 4-deep FIFO model
module tb_fifo_access_ctrl;

  localparam logic [2:0] DEEP = 3'd4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_access_ctrl_if bus();

  fifo_access_ctrl #(.DEEP(3'd4), .BURST(3'd2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model: registered read data, count-based free slots
  logic [7:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic [7:0] rdata;
  logic       wr_ok, rd_ok;

  assign wr_ok            = bus.fifo_wr_req && (cnt != 3'd4);
  assign rd_ok            = bus.fifo_rd_req && (cnt != 3'd0);
  assign bus.fifo_left    = DEEP - cnt;
  assign bus.fifo_rd_data = rdata;

  always @(posedge clk) begin
    if (rst) begin
      wp    <= 2'd0;
      rp    <= 2'd0;
      cnt   <= 3'd0;
      rdata <= 8'h00;
    end else begin
      chk("wr_when_full", {31'd0, bus.fifo_wr_req && (cnt == 3'd4)}, 32'd0);
      chk("rd_when_empty", {31'd0, bus.fifo_rd_req && (cnt == 3'd0)}, 32'd0);
      if (wr_ok) begin
        mem[wp] <= bus.fifo_wr_data;
        wp      <= wp + 2'd1;
      end
      if (rd_ok) begin
        rdata <= mem[rp];
        rp    <= rp + 2'd1;
      end
      cnt <= cnt + (wr_ok ? 3'd1 : 3'd0) - (rd_ok ? 3'd1 : 3'd0);
    end
  end

  // Scoreboard: expected bytes in write order, popped on each rd_valid
  logic [7:0] exp_q [$];
  int         rv_cnt = 0;

  always @(negedge clk) begin
    if (!rst && bus.rd_valid) begin
      rv_cnt++;
      if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else chk("rd_data_sb", {24'd0, bus.rd_data}, {24'd0, exp_q.pop_front()});
    end
  end

  logic [7:0] d0, d1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive();
    bus.wr0_data = d0;
    bus.wr1_data = d1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rd_req = 1'b0;
    exp_q.delete();
    smp();
    step();
    smp();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.rd_req = 1'b1;
    repeat (n) begin
      smp();
      step();
    end
    chk("drain_no_rd_empty", {31'd0, bus.fifo_rd_req}, 32'd0);
    bus.rd_req = 1'b0;
    repeat (3) begin
      smp();
      step();
    end
    chk("drain_q_left", exp_q.size(), 32'd0);
    chk("drain_empty", {31'd0, bus.empty}, 32'd1);
  endtask

  int a0 [6] = '{0, 1, 1, 0, 0, 0};
  int a1 [6] = '{0, 0, 0, 1, 1, 0};
  int lf [6] = '{4, 4, 3, 2, 1, 0};
  int a5 [6] = '{0, 1, 1, 0, 1, 1};
  int base, rdp;

  initial begin
    rst = 1'b1;
    bus.wr0_req = 1'b0;
    bus.wr1_req = 1'b0;
    bus.rd_req  = 1'b0;
    d0 = 8'h00;
    d1 = 8'h00;
    drive();

    // reset state
    step();
    smp();
    chk("rst_ack0", {31'd0, bus.wr0_ack}, 32'd0);
    chk("rst_ack1", {31'd0, bus.wr1_ack}, 32'd0);
    chk("rst_fifo_wr", {31'd0, bus.fifo_wr_req}, 32'd0);
    chk("rst_fifo_rd", {31'd0, bus.fifo_rd_req}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    step();
    rst = 1'b0;

    // 1: single ch0 write after an arbitration cycle
    d0 = 8'hA1;
    drive();
    bus.wr0_req = 1'b1;
    smp();
    chk("t1_idle_ack", {31'd0, bus.wr0_ack}, 32'd0);
    chk("t1_idle_wr", {31'd0, bus.fifo_wr_req}, 32'd0);
    chk("t1_idle_data", {24'd0, bus.fifo_wr_data}, 32'd0);
    step();
    smp();
    chk("t1_ack", {31'd0, bus.wr0_ack}, 32'd1);
    chk("t1_wr", {31'd0, bus.fifo_wr_req}, 32'd1);
    chk("t1_data", {24'd0, bus.fifo_wr_data}, 32'hA1);
    exp_q.push_back(8'hA1);
    step();
    bus.wr0_req = 1'b0;
    smp();
    chk("t1_drop_ack", {31'd0, bus.wr0_ack}, 32'd0);
    step();
    drain(3);

    // 2: both channels, bursts of two, until full
    d0 = 8'h10;
    d1 = 8'h20;
    drive();
    bus.wr0_req = 1'b1;
    bus.wr1_req = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      smp();
      chk($sformatf("t2_ack0_%0d", i), {31'd0, bus.wr0_ack}, a0[i]);
      chk($sformatf("t2_ack1_%0d", i), {31'd0, bus.wr1_ack}, a1[i]);
      chk($sformatf("t2_left_%0d", i), {29'd0, bus.fifo_left}, lf[i]);
      if (a0[i] != 0) begin
        chk($sformatf("t2_wdata_%0d", i), {24'd0, bus.fifo_wr_data}, {24'd0, d0});
        exp_q.push_back(d0);
      end
      if (a1[i] != 0) begin
        chk($sformatf("t2_wdata_%0d", i), {24'd0, bus.fifo_wr_data}, {24'd0, d1});
        exp_q.push_back(d1);
      end
      step();
      if (a0[i] != 0) d0 = d0 + 8'd1;
      if (a1[i] != 0) d1 = d1 + 8'd1;
      drive();
    end
    chk("t2_full", {31'd0, bus.full}, 32'd1);

    // 3: full with ch1 granted, one read frees a slot for ch1
    bus.wr0_req = 1'b0;
    smp();
    chk("t3_hand_ack0", {31'd0, bus.wr0_ack}, 32'd0);
    chk("t3_hand_ack1", {31'd0, bus.wr1_ack}, 32'd0);
    step();
    bus.rd_req = 1'b1;
    smp();
    chk("t3_rd", {31'd0, bus.fifo_rd_req}, 32'd1);
    chk("t3_no_wr", {31'd0, bus.fifo_wr_req}, 32'd0);
    step();
    bus.rd_req = 1'b0;
    smp();
    chk("t3_ack1", {31'd0, bus.wr1_ack}, 32'd1);
    chk("t3_left", {29'd0, bus.fifo_left}, 32'd1);
    chk("t3_wdata", {24'd0, bus.fifo_wr_data}, {24'd0, d1});
    exp_q.push_back(d1);
    step();
    bus.wr1_req = 1'b0;
    smp();
    chk("t3_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("t3_rd_oldest", {24'd0, bus.rd_data}, 32'h10);
    step();
    drain(6);

    // 4: read suppressed while empty, write goes first
    d0 = 8'h55;
    drive();
    bus.wr0_req = 1'b1;
    do_reset();
    bus.rd_req = 1'b1;
    smp();
    chk("t4_c1_rd", {31'd0, bus.fifo_rd_req}, 32'd0);
    step();
    smp();
    chk("t4_c2_ack", {31'd0, bus.wr0_ack}, 32'd1);
    chk("t4_c2_rd", {31'd0, bus.fifo_rd_req}, 32'd0);
    exp_q.push_back(8'h55);
    step();
    bus.wr0_req = 1'b0;
    smp();
    chk("t4_c3_rd", {31'd0, bus.fifo_rd_req}, 32'd1);
    step();
    bus.rd_req = 1'b0;
    smp();
    chk("t4_c4_valid", {31'd0, bus.rd_valid}, 32'd0);
    step();
    smp();
    chk("t4_c5_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("t4_c5_data", {24'd0, bus.rd_data}, 32'h55);
    step();
    chk("t4_q", exp_q.size(), 32'd0);

    // 5: four bytes in, six read cycles out, exactly four pulses in order
    d0 = 8'h01;
    drive();
    bus.wr0_req = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      smp();
      chk($sformatf("t5_ack_%0d", i), {31'd0, bus.wr0_ack}, a5[i]);
      if (a5[i] != 0) exp_q.push_back(d0);
      step();
      if (a5[i] != 0) d0 = d0 + 8'd1;
      drive();
    end
    bus.wr0_req = 1'b0;
    base = rv_cnt;
    rdp = 0;
    bus.rd_req = 1'b1;
    repeat (6) begin
      smp();
      if (bus.fifo_rd_req) rdp++;
      step();
    end
    bus.rd_req = 1'b0;
    repeat (3) begin
      smp();
      step();
    end
    chk("t5_pulses", rv_cnt - base, 32'd4);
    chk("t5_rd_issued", rdp, 32'd4);
    chk("t5_empty", {31'd0, bus.empty}, 32'd1);
    chk("t5_q", exp_q.size(), 32'd0);

    // 6: reset mid-burst in GNT1 with a read pending
    d0 = 8'h40;
    d1 = 8'h60;
    drive();
    bus.wr0_req = 1'b1;
    bus.wr1_req = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("t6_ack0_%0d", i), {31'd0, bus.wr0_ack}, a0[i]);
      chk($sformatf("t6_ack1_%0d", i), {31'd0, bus.wr1_ack}, a1[i]);
      step();
      if (a0[i] != 0) d0 = d0 + 8'd1;
      if (a1[i] != 0) d1 = d1 + 8'd1;
      drive();
      if (i == 2) bus.rd_req = 1'b1;
    end
    rst = 1'b1;
    exp_q.delete();
    smp();
    chk("t6_rst_ack0", {31'd0, bus.wr0_ack}, 32'd0);
    chk("t6_rst_ack1", {31'd0, bus.wr1_ack}, 32'd0);
    chk("t6_rst_rd", {31'd0, bus.fifo_rd_req}, 32'd0);
    chk("t6_rst_wr", {31'd0, bus.fifo_wr_req}, 32'd0);
    step();
    smp();
    chk("t6_rst_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("t6_rst_ack1b", {31'd0, bus.wr1_ack}, 32'd0);
    step();
    rst = 1'b0;
    bus.rd_req = 1'b0;
    smp();
    chk("t6_idle_ack0", {31'd0, bus.wr0_ack}, 32'd0);
    chk("t6_idle_ack1", {31'd0, bus.wr1_ack}, 32'd0);
    step();
    smp();
    chk("t6_prio_ack0", {31'd0, bus.wr0_ack}, 32'd1);
    chk("t6_prio_ack1", {31'd0, bus.wr1_ack}, 32'd0);
    chk("t6_prio_data", {24'd0, bus.fifo_wr_data}, {24'd0, d0});
    step();
    bus.wr0_req = 1'b0;
    bus.wr1_req = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
